// File: rtl/rvtu_valid_ctrl.sv
// rvtu_valid_ctrl: sequencer and arbiter for the RVTU 1-bit valid array.
// One array port is shared by invalidate, fill and lookup requesters
// (fixed priority inv > fill > lk). A non-reset flush walks every entry
// and writes 0. The array has a registered read address, so a lookup
// granted in one cycle returns its valid bit in the following cycle.
module rvtu_valid_ctrl #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lk_req,
  input  logic [AW-1:0] lk_addr,
  output logic          lk_ready,
  output logic          lk_rsp_valid,
  output logic          lk_rsp_hit,
  input  logic          fill_req,
  input  logic [AW-1:0] fill_addr,
  output logic          fill_ready,
  input  logic          inv_req,
  input  logic [AW-1:0] inv_addr,
  output logic          inv_ready,
  input  logic          flush_req,
  output logic          flush_busy,
  output logic          flush_done,
  output logic [AW-1:0] arr_addr,
  output logic          arr_wdata,
  output logic          arr_wen,
  input  logic          arr_rdata
);

  localparam logic [0:0]    IDLE  = 1'b0;
  localparam logic [0:0]    FLUSH = 1'b1;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  logic [0:0]    state;
  logic [AW-1:0] flush_cnt;
  // Last index presented to the array; arr_addr holds it on idle cycles.
  logic [AW-1:0] addr_q;

  // Fixed-priority grant; nothing is granted during rst, in FLUSH, or in
  // the IDLE cycle that accepts a flush request.
  always_comb begin
    inv_ready  = 1'b0;
    fill_ready = 1'b0;
    lk_ready   = 1'b0;
    if (!rst && state == IDLE && !flush_req) begin
      if (inv_req)       inv_ready  = 1'b1;
      else if (fill_req) fill_ready = 1'b1;
      else if (lk_req)   lk_ready   = 1'b1;
    end
  end

  // Array port mux: flush walk, then the granted requester, else hold.
  always_comb begin
    arr_addr  = addr_q;
    arr_wen   = 1'b0;
    arr_wdata = 1'b0;
    if (!rst) begin
      if (state == FLUSH) begin
        arr_addr = flush_cnt;
        arr_wen  = 1'b1;
      end else if (inv_ready) begin
        arr_addr = inv_addr;
        arr_wen  = 1'b1;
      end else if (fill_ready) begin
        arr_addr  = fill_addr;
        arr_wen   = 1'b1;
        arr_wdata = 1'b1;
      end else if (lk_ready) begin
        arr_addr = lk_addr;
      end
    end
  end

  // Flush status is decoded from state so an aborting rst suppresses it.
  always_comb begin
    flush_busy = !rst && (state == FLUSH);
    flush_done = flush_busy && (flush_cnt == LAST);
  end

  // The hit bit is the array read data for the lookup granted last cycle.
  always_comb begin
    lk_rsp_hit = lk_rsp_valid & arr_rdata;
  end

  // Control state: FSM, flush counter, response valid, held address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      flush_cnt    <= '0;
      lk_rsp_valid <= 1'b0;
      addr_q       <= '0;
    end else begin
      lk_rsp_valid <= lk_req & lk_ready;
      addr_q       <= arr_addr;
      if (state == IDLE) begin
        flush_cnt <= '0;
        if (flush_req) state <= FLUSH;
      end else begin
        if (flush_cnt == LAST) begin
          state     <= IDLE;
          flush_cnt <= '0;
        end else begin
          flush_cnt <= flush_cnt + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rvtu_valid_ctrl.sv
// Bench for rvtu_valid_ctrl: a behavioural valid array sits on the array
// port, and a reference valid vector plus priority rules predict results.
module tb_rvtu_valid_ctrl;

  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          lk_req, fill_req, inv_req, flush_req;
  logic [AW-1:0] lk_addr, fill_addr, inv_addr;
  logic          lk_ready, lk_rsp_valid, lk_rsp_hit;
  logic          fill_ready, inv_ready, flush_busy, flush_done;
  logic [AW-1:0] arr_addr;
  logic          arr_wdata, arr_wen, arr_rdata;

  int total = 0;
  int bad   = 0;

  // Array behaviour: cleared by rst, 1-cycle registered-address read.
  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    raddr;
  always @(posedge clk) begin
    if (rst) mem <= '0;
    else if (arr_wen) mem[arr_addr] <= arr_wdata;
    raddr <= arr_addr;
  end
  assign arr_rdata = mem[raddr];

  always #5 clk = ~clk;

  rvtu_valid_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .lk_req(lk_req), .lk_addr(lk_addr), .lk_ready(lk_ready),
    .lk_rsp_valid(lk_rsp_valid), .lk_rsp_hit(lk_rsp_hit),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_ready(fill_ready),
    .inv_req(inv_req), .inv_addr(inv_addr), .inv_ready(inv_ready),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .arr_addr(arr_addr), .arr_wdata(arr_wdata), .arr_wen(arr_wen),
    .arr_rdata(arr_rdata)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lk_req = 0; fill_req = 0; inv_req = 0; flush_req = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cyc(); cyc();
    rst = 0;
  endtask

  // Single fill transfer, assumes no competing request.
  task automatic do_fill(input logic [AW-1:0] a);
    fill_req = 1; fill_addr = a;
    #1;
    total++;
    if (fill_ready !== 1'b1) begin
      bad++; $display("FAIL fill_grant addr=%0d got=%b want=1", a, fill_ready);
    end
    cyc();
    fill_req = 0;
  endtask

  // Lookup: grant this cycle, response next cycle with the expected hit.
  task automatic do_lookup(input logic [AW-1:0] a, input logic exp_hit, input string nm);
    lk_req = 1; lk_addr = a;
    #1;
    total++;
    if (lk_ready !== 1'b1 || arr_wen !== 1'b0 || arr_addr !== a) begin
      bad++; $display("FAIL %s_grant rdy=%b wen=%b addr=%0d want rdy=1 wen=0 addr=%0d",
                      nm, lk_ready, arr_wen, arr_addr, a);
    end
    cyc();
    lk_req = 0;
    #1;
    total++;
    if (lk_rsp_valid !== 1'b1 || lk_rsp_hit !== exp_hit) begin
      bad++; $display("FAIL %s_rsp valid=%b hit=%b want valid=1 hit=%b",
                      nm, lk_rsp_valid, lk_rsp_hit, exp_hit);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (lk_rsp_valid !== 0 || flush_busy !== 0 || flush_done !== 0 || arr_wen !== 0 ||
        lk_ready !== 0 || fill_ready !== 0 || inv_ready !== 0) begin
      bad++; $display("FAIL reset_state rspv=%b busy=%b done=%b wen=%b rdy=%b%b%b want all 0",
                      lk_rsp_valid, flush_busy, flush_done, arr_wen, inv_ready, fill_ready, lk_ready);
    end
    cyc();
  endtask

  task automatic test_basic();
    do_lookup(7'd5, 1'b0, "basic_miss5");
    cyc();
    do_fill(7'd5);
    do_lookup(7'd5, 1'b1, "basic_hit5");
    cyc();
  endtask

  task automatic test_priority();
    do_fill(7'd9);
    inv_req = 1; fill_req = 1; lk_req = 1;
    inv_addr = 9; fill_addr = 9; lk_addr = 9;
    #1;
    total++;
    if ({inv_ready, fill_ready, lk_ready} !== 3'b100 || arr_wdata !== 0 || arr_wen !== 1) begin
      bad++; $display("FAIL prio_c0 rdy=%b%b%b wen=%b wd=%b want 100 wen=1 wd=0",
                      inv_ready, fill_ready, lk_ready, arr_wen, arr_wdata);
    end
    cyc(); inv_req = 0; #1;
    total++;
    if ({inv_ready, fill_ready, lk_ready} !== 3'b010 || arr_wdata !== 1 || arr_wen !== 1) begin
      bad++; $display("FAIL prio_c1 rdy=%b%b%b wen=%b wd=%b want 010 wen=1 wd=1",
                      inv_ready, fill_ready, lk_ready, arr_wen, arr_wdata);
    end
    cyc(); fill_req = 0; #1;
    total++;
    if ({inv_ready, fill_ready, lk_ready} !== 3'b001 || arr_wen !== 0) begin
      bad++; $display("FAIL prio_c2 rdy=%b%b%b wen=%b want 001 wen=0",
                      inv_ready, fill_ready, lk_ready, arr_wen);
    end
    cyc(); lk_req = 0; #1;
    total++;
    if (lk_rsp_valid !== 1 || lk_rsp_hit !== 1) begin
      bad++; $display("FAIL prio_c3 valid=%b hit=%b want valid=1 hit=1", lk_rsp_valid, lk_rsp_hit);
    end
    cyc();
  endtask

  task automatic test_flush();
    int errs;
    do_fill(7'd0); do_fill(7'd64); do_fill(7'd127);
    flush_req = 1; lk_req = 1; lk_addr = 0;
    #1;
    total++;
    if (lk_ready !== 0 || arr_wen !== 0 || flush_busy !== 0) begin
      bad++; $display("FAIL flush_req_cycle rdy=%b wen=%b busy=%b want 0 0 0",
                      lk_ready, arr_wen, flush_busy);
    end
    cyc();
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      flush_req = (i == 50);
      #1;
      total++;
      if (flush_busy !== 1 || arr_wen !== 1 || arr_wdata !== 0 || arr_addr !== AW'(i) ||
          flush_done !== (i == DEPTH - 1) || lk_ready !== 0 || fill_ready !== 0 || inv_ready !== 0) begin
        bad++; errs++;
        if (errs < 5)
          $display("FAIL flush_walk i=%0d busy=%b wen=%b wd=%b addr=%0d done=%b lkrdy=%b want 1 1 0 %0d %b 0",
                   i, flush_busy, arr_wen, arr_wdata, arr_addr, flush_done, lk_ready, i, (i == DEPTH - 1));
      end
      cyc();
    end
    flush_req = 0;
    #1;
    total++;
    if (flush_busy !== 0 || flush_done !== 0 || lk_ready !== 1 || arr_addr !== 0 || arr_wen !== 0) begin
      bad++; $display("FAIL flush_exit busy=%b done=%b lkrdy=%b addr=%0d wen=%b want 0 0 1 0 0",
                      flush_busy, flush_done, lk_ready, arr_addr, arr_wen);
    end
    cyc();
    lk_req = 0;
    #1;
    total++;
    if (lk_rsp_valid !== 1 || lk_rsp_hit !== 0 || flush_busy !== 0) begin
      bad++; $display("FAIL flush_lk0 valid=%b hit=%b busy=%b want 1 0 0", lk_rsp_valid, lk_rsp_hit, flush_busy);
    end
    cyc();
    do_lookup(7'd64, 1'b0, "flush_lk64");
    do_lookup(7'd127, 1'b0, "flush_lk127");
    total++;
    if (flush_busy !== 0) begin
      bad++; $display("FAIL flush_no_second busy=%b want 0", flush_busy);
    end
    cyc();
  endtask

  task automatic test_rst_mid_flush();
    int dones;
    do_fill(7'd10); do_fill(7'd100);
    flush_req = 1;
    cyc();
    flush_req = 0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (flush_done === 1) dones++;
      cyc();
    end
    rst = 1;
    #1;
    total++;
    if (arr_wen !== 0 || flush_done !== 0) begin
      bad++; $display("FAIL rstflush_during wen=%b done=%b want 0 0", arr_wen, flush_done);
    end
    cyc();
    rst = 0;
    #1;
    total++;
    if (flush_busy !== 0 || flush_done !== 0 || dones !== 0 || lk_rsp_valid !== 0) begin
      bad++; $display("FAIL rstflush_after busy=%b done=%b earlydones=%0d rspv=%b want 0 0 0 0",
                      flush_busy, flush_done, dones, lk_rsp_valid);
    end
    do_lookup(7'd10, 1'b0, "rstflush_lk10");
    cyc();
    do_lookup(7'd100, 1'b0, "rstflush_lk100");
    cyc();
  endtask

  task automatic test_back_to_back();
    do_fill(7'd3);
    inv_req = 1; inv_addr = 4; cyc(); inv_req = 0;
    lk_req = 1; lk_addr = 3;
    #1;
    total++;
    if (lk_ready !== 1) begin
      bad++; $display("FAIL b2b_grant3 rdy=%b want 1", lk_ready);
    end
    cyc();
    lk_addr = 4;
    #1;
    total++;
    if (lk_ready !== 1 || lk_rsp_valid !== 1 || lk_rsp_hit !== 1) begin
      bad++; $display("FAIL b2b_rsp3 rdy=%b valid=%b hit=%b want 1 1 1", lk_ready, lk_rsp_valid, lk_rsp_hit);
    end
    cyc();
    lk_req = 0; fill_req = 1; fill_addr = 4;
    #1;
    total++;
    if (fill_ready !== 1 || lk_rsp_valid !== 1 || lk_rsp_hit !== 0) begin
      bad++; $display("FAIL b2b_rsp4 fillrdy=%b valid=%b hit=%b want 1 1 0", fill_ready, lk_rsp_valid, lk_rsp_hit);
    end
    cyc();
    fill_req = 0;
    #1;
    total++;
    if (lk_rsp_valid !== 0) begin
      bad++; $display("FAIL b2b_rspv_drop valid=%b want 0", lk_rsp_valid);
    end
    do_lookup(7'd4, 1'b1, "b2b_after_fill4");
    cyc();
  endtask

  // Random traffic against a reference valid vector and priority rules.
  task automatic test_random();
    logic [DEPTH-1:0] ref_valid;
    logic             exp_v, exp_h, nxt_v, nxt_h;
    logic             g_inv, g_fill, g_lk, have_last;
    logic [AW-1:0]    last_addr, exp_addr;
    int               errs;
    do_reset();
    ref_valid = '0;
    exp_v = 0; exp_h = 0; have_last = 0; last_addr = 0; errs = 0;
    for (int n = 0; n < 600; n++) begin
      inv_req   = ($urandom_range(0, 3) == 0);
      fill_req  = ($urandom_range(0, 2) == 0);
      lk_req    = ($urandom_range(0, 1) == 0);
      inv_addr  = AW'($urandom_range(0, 7));
      fill_addr = AW'($urandom_range(0, 7));
      lk_addr   = AW'($urandom_range(0, 7));
      g_inv  = inv_req;
      g_fill = fill_req && !inv_req;
      g_lk   = lk_req && !inv_req && !fill_req;
      exp_addr = g_inv ? inv_addr : g_fill ? fill_addr : g_lk ? lk_addr : last_addr;
      #1;
      total++;
      if (inv_ready !== g_inv || fill_ready !== g_fill || lk_ready !== g_lk ||
          lk_rsp_valid !== exp_v || (exp_v && lk_rsp_hit !== exp_h) ||
          arr_wen !== (g_inv || g_fill) || ((g_inv || g_fill) && arr_wdata !== g_fill) ||
          ((have_last || g_inv || g_fill || g_lk) && arr_addr !== exp_addr)) begin
        bad++; errs++;
        if (errs < 5)
          $display("FAIL rand n=%0d rdy=%b%b%b want %b%b%b rsp=%b/%b want %b/%b wen=%b addr=%0d want_addr=%0d",
                   n, inv_ready, fill_ready, lk_ready, g_inv, g_fill, g_lk,
                   lk_rsp_valid, lk_rsp_hit, exp_v, exp_h, arr_wen, arr_addr, exp_addr);
      end
      nxt_v = g_lk;
      nxt_h = g_lk ? ref_valid[lk_addr] : 1'b0;
      if (g_inv)  ref_valid[inv_addr]  = 1'b0;
      if (g_fill) ref_valid[fill_addr] = 1'b1;
      if (g_inv || g_fill || g_lk) begin
        have_last = 1; last_addr = exp_addr;
      end
      exp_v = nxt_v; exp_h = nxt_h;
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    lk_addr = 0; fill_addr = 0; inv_addr = 0;
    #2;
    test_reset();
    test_basic();
    test_priority();
    test_flush();
    test_rst_mid_flush();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
